fmul_norm_round: RTL and testbench
==================================

# fmul_norm_round

Two-stage pipelined normalize-and-round stage for the single-precision FPU multiply path. It sits directly downstream of `imul`. It consumes the 2*MW-bit unsigned significand product together with the result sign, the biased exponent sum and the special-case flags. It produces a packed IEEE-754 binary32 result with status flags. A valid/ready handshake applies on both sides.

## Interface
- `MW`, 24: significand width including hidden bit; product width is 2*MW.
- `EW`, 8: exponent field width.
- `BIAS`, 127: exponent bias.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  upstream has a product.
- `in_ready`  output  1  stage accepts the product this cycle.
- `in_prod`  input  2*MW  unsigned product of the two significands (hidden bits included).
- `in_sign`  input  1  result sign (sign_a XOR sign_b).
- `in_exp_sum`  input  EW+2  unsigned sum of the two biased exponent fields (0..508).
- `in_nan`  input  1  result is NaN. Upstream asserts this for NaN operands and for inf*0.
- `in_inf`  input  1  result is infinity.
- `in_zero`  input  1  result is zero.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream consumes the result this cycle.
- `out_result`  output  1+EW+MW-1  {sign, exponent, fraction}.
- `out_flags`  output  3  {overflow, underflow, inexact}.

## Operation
- Stage 1 (normalize), registered:
  - If in_prod[2MW-1] = 1: frac = prod[2MW-2:MW], guard = prod[MW-1], sticky = OR of prod[MW-2:0], exp = exp_sum − BIAS + 1.
  - Otherwise: frac = prod[2MW-3:MW-1], guard = prod[MW-2], sticky = OR of prod[MW-3:0], exp = exp_sum − BIAS.
  - exp is held as an EW+3-bit signed value. No intermediate truncation is allowed.
  - Sign and special flags are registered alongside.
- Stage 2 (round/pack), registered:
  - Round to nearest, ties to even: increment when guard & (sticky | frac[0]).
  - On fraction carry-out, frac = 0 and exp = exp + 1.
  - inexact = guard | sticky.
  - If exp ≥ 2^EW − 1 after rounding: result = ±inf, overflow = 1, inexact = 1.
  - If exp ≤ 0: flush to ±0 (no subnormals), underflow = 1, inexact = 1.
  - Otherwise: result = {sign, exp[EW-1:0], frac}.
- Special precedence: nan > inf > zero > normal.
  - NaN outputs 0x7FC00000 (canonical quiet NaN, sign 0).
  - inf outputs {sign, all-ones, 0}.
  - zero outputs {sign, 0, 0}.
  - All special cases have flags = 0.
  - in_prod and in_exp_sum are ignored whenever any special flag is set.

## Timing
- Enables:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en. This is combinational from out_ready, with no bubble.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Latency is 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- s1_valid loads in_valid when s1_en.
- s2_valid loads s1_valid when s2_en.
- Data registers load only when their enable is high. They hold otherwise.
- out_result and out_flags stay stable while out_valid & !out_ready.
- Backpressure capacity is 2 items, one per stage. No item is dropped or duplicated, and order is preserved.
- Reset (asynchronous, any time, including mid-operation):
  - out_valid = 0, out_result = 0, out_flags = 0, internal valids = 0.
  - in_ready = 1 during and after reset.
  - In-flight items are discarded.
- Simultaneous output consume and input accept while full is a legal full-throughput advance.

## Test plan
- 1.0×1.0: prod 0x400000000000, exp_sum 254 -> 0x3F800000, flags 000, valid 2 cycles later.
- 1.5×1.5: prod 0x900000000000, exp_sum 254 -> 0x40100000, flags 000.
- Rounding:
  - Tie, even LSB: prod 0x400000400000 -> 0x3F800000, inexact.
  - Tie, odd LSB: prod 0x400000C00000 -> 0x3F800002, inexact.
  - Carry-out: prod 0x7FFFFFC00000, exp_sum 254 -> 0x40000000, inexact.
- Range limits with prod 0x400000000000:
  - exp_sum 400, sign 1 -> 0xFF800000, flags 101.
  - exp_sum 100 -> 0x00000000, flags 011.
- Specials:
  - nan+inf+zero set -> 0x7FC00000.
  - inf with sign 1 -> 0xFF800000.
  - zero with sign 1 -> 0x80000000.
  - Random prod/exp_sum is ignored in all three cases, and flags are 000.
- Backpressure: stream 5 items with out_ready low for cycles 3–6.
  - in_ready drops once 2 items are held.
  - out_result is stable while stalled.
  - All 5 results emerge in order.
  - Assert rst_n low mid-stream: out_valid falls immediately, and the next item after release has latency 2.

Source files
------------

// File: rtl/fmul_norm_round_if.sv
// rtl/fmul_norm_round_if.sv - handshake and data bundle between imul, the normalize/round stage and its consumer
interface fmul_norm_round_if #(
   parameter int MW = 24,
   parameter int EW = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [2*MW-1:0]   in_prod;
   logic              in_sign;
   logic [EW+1:0]     in_exp_sum;
   logic              in_nan;
   logic              in_inf;
   logic              in_zero;
   logic              out_valid;
   logic              out_ready;
   logic [EW+MW-1:0]  out_result;
   logic [2:0]        out_flags;

   modport master (
      output in_valid, in_prod, in_sign, in_exp_sum, in_nan, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_prod, in_sign, in_exp_sum, in_nan, in_inf, in_zero, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - two-stage normalize and round-to-nearest-even pack for the binary32 multiply path
module fmul_norm_round #(
   parameter int MW   = 24,
   parameter int EW   = 8,
   parameter int BIAS = 127
) (
   input  logic               clk,
   input  logic               rst_n,
   fmul_norm_round_if.slave   bus
);
   localparam int PW = 2 * MW;
   localparam int XW = EW + 3;
   localparam int RW = EW + MW;

   logic s1_en;
   logic s2_en;

   logic                 s1_valid_q;
   logic [MW-2:0]        s1_frac_q;
   logic                 s1_guard_q;
   logic                 s1_sticky_q;
   logic signed [XW-1:0] s1_exp_q;
   logic                 s1_sign_q;
   logic                 s1_nan_q;
   logic                 s1_inf_q;
   logic                 s1_zero_q;

   logic                 s2_valid_q;
   logic [RW-1:0]        out_result_q;
   logic [2:0]           out_flags_q;

   assign s2_en         = !s2_valid_q || bus.out_ready;
   assign s1_en         = !s1_valid_q || s2_en;
   assign bus.in_ready  = s1_en;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_flags  = out_flags_q;

   // Stage 1: pick the normalization window by the product MSB.
   logic signed [XW-1:0] exp_base;
   logic [MW-2:0]        s1_frac_d;
   logic                 s1_guard_d;
   logic                 s1_sticky_d;
   logic signed [XW-1:0] s1_exp_d;

   assign exp_base = $signed({1'b0, bus.in_exp_sum}) - XW'(BIAS);

   always_comb begin
      if (bus.in_prod[PW-1]) begin
         s1_frac_d   = bus.in_prod[PW-2:MW];
         s1_guard_d  = bus.in_prod[MW-1];
         s1_sticky_d = |bus.in_prod[MW-2:0];
         s1_exp_d    = exp_base + XW'(1);
      end else begin
         s1_frac_d   = bus.in_prod[PW-3:MW-1];
         s1_guard_d  = bus.in_prod[MW-2];
         s1_sticky_d = |bus.in_prod[MW-3:0];
         s1_exp_d    = exp_base;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_frac_q   <= '0;
         s1_guard_q  <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_exp_q    <= '0;
         s1_sign_q   <= 1'b0;
         s1_nan_q    <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_zero_q   <= 1'b0;
      end else if (s1_en) begin
         s1_valid_q  <= bus.in_valid;
         s1_frac_q   <= s1_frac_d;
         s1_guard_q  <= s1_guard_d;
         s1_sticky_q <= s1_sticky_d;
         s1_exp_q    <= s1_exp_d;
         s1_sign_q   <= bus.in_sign;
         s1_nan_q    <= bus.in_nan;
         s1_inf_q    <= bus.in_inf;
         s1_zero_q   <= bus.in_zero;
      end
   end

   // Stage 2: round, then range-check the post-rounding exponent.
   logic                 round_up;
   logic                 inexact;
   logic [MW-1:0]        frac_inc;
   logic signed [XW-1:0] exp_r;
   logic                 exp_ovf;
   logic                 exp_unf;
   logic [RW-1:0]        out_result_d;
   logic [2:0]           out_flags_d;

   assign round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
   assign inexact  = s1_guard_q | s1_sticky_q;
   assign frac_inc = {1'b0, s1_frac_q} + MW'(round_up);
   assign exp_r    = s1_exp_q + (frac_inc[MW-1] ? XW'(1) : XW'(0));
   assign exp_ovf  = !exp_r[XW-1] && (exp_r[XW-2:0] >= (XW-1)'((1 << EW) - 1));
   assign exp_unf  = exp_r[XW-1] || (exp_r == '0);

   always_comb begin
      out_result_d = '0;
      out_flags_d  = 3'b000;
      if (s1_nan_q) begin
         out_result_d = {1'b0, {EW{1'b1}}, 1'b1, {(MW-2){1'b0}}};
      end else if (s1_inf_q) begin
         out_result_d = {s1_sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
      end else if (s1_zero_q) begin
         out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
      end else if (exp_ovf) begin
         out_result_d = {s1_sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
         out_flags_d  = 3'b101;
      end else if (exp_unf) begin
         out_result_d = {s1_sign_q, {(RW-1){1'b0}}};
         out_flags_d  = 3'b011;
      end else begin
         out_result_d = {s1_sign_q, exp_r[EW-1:0], frac_inc[MW-2:0]};
         out_flags_d  = {2'b00, inexact};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q   <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= 3'b000;
      end else if (s2_en) begin
         s2_valid_q   <= s1_valid_q;
         out_result_q <= out_result_d;
         out_flags_q  <= out_flags_d;
      end
   end
endmodule

// File: tb/tb_fmul_norm_round.sv
// tb/tb_fmul_norm_round.sv - self-checking bench for fmul_norm_round with a reference rounding model
module tb_fmul_norm_round;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fmul_norm_round_if #(.MW(24), .EW(8)) bus ();

   fmul_norm_round #(.MW(24), .EW(8), .BIAS(127)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      errors++;
      $error("FAIL watchdog expired before the test completed");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   logic [34:0] expq[$];
   int          occ = 0;
   logic        stalled = 1'b0;
   logic [34:0] held;
   logic        accepted;

   // Value semantics: significand = prod / 2^46, value = significand * 2^(exp_sum-254).
   function automatic logic [34:0] ref_model(input logic [47:0] p, input logic s, input int es,
                                             input logic n, input logic i, input logic z);
      logic [63:0] pl, mant, rem, half;
      int          sh, e;
      logic        inx;
      if (n) return {3'b000, 32'h7FC00000};
      if (i) return {3'b000, s, 8'hFF, 23'h0};
      if (z) return {3'b000, s, 31'h0};
      pl   = {16'h0, p};
      sh   = p[47] ? 24 : 23;
      e    = es - 127 + (p[47] ? 1 : 0);
      mant = pl >> sh;
      rem  = pl & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
      if (e <= 0)   return {3'b011, s, 31'h0};
      return {2'b00, inx, s, e[7:0], mant[22:0]};
   endfunction

   task automatic cycle();
      logic [34:0] obs, e;
      logic        exp_rdy;
      @(negedge clk);
      obs = {bus.out_flags, bus.out_result};
      if (stalled) begin
         chk("hold_valid", bus.out_valid, 1'b1);
         chk("hold_data", obs, held);
      end
      exp_rdy = (occ < 2) || bus.out_ready;
      chk("in_ready", bus.in_ready, exp_rdy);
      if (bus.out_valid && bus.out_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_output", bus.out_valid, 1'b0);
         end else begin
            e = expq.pop_front();
            chk("stream_result", obs, e);
            occ--;
         end
      end
      stalled  = bus.out_valid && !bus.out_ready;
      held     = obs;
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
         expq.push_back(ref_model(bus.in_prod, bus.in_sign, int'(bus.in_exp_sum),
                                  bus.in_nan, bus.in_inf, bus.in_zero));
         occ++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      logic [47:0] a, b;
      int          r;
      a = {24'h0, 1'b1, 23'($urandom)};
      b = {24'h0, 1'b1, 23'($urandom)};
      bus.in_prod = a * b;
      if ($urandom_range(0, 3) == 0) bus.in_prod[21:0] = 22'h0;
      bus.in_sign    = 1'($urandom);
      bus.in_exp_sum = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 508))
                                                  : 10'($urandom_range(200, 310));
      r = $urandom_range(0, 15);
      bus.in_nan  = (r == 0) || (r == 3);
      bus.in_inf  = (r == 1) || (r == 3);
      bus.in_zero = (r == 2) || (r == 3);
   endtask

   task automatic directed(input string tag, input logic [47:0] p, input logic s, input int es,
                           input logic n, input logic i, input logic z,
                           input logic [31:0] exp_res, input logic [2:0] exp_flg);
      bus.in_prod    = p;
      bus.in_sign    = s;
      bus.in_exp_sum = 10'(es);
      bus.in_nan     = n;
      bus.in_inf     = i;
      bus.in_zero    = z;
      bus.in_valid   = 1'b1;
      bus.out_ready  = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, "_lat2"}, bus.out_valid, 1'b1);
      chk({tag, "_result"}, bus.out_result, exp_res);
      chk({tag, "_flags"}, bus.out_flags, exp_flg);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_prod    = '0;
      bus.in_sign    = 1'b0;
      bus.in_exp_sum = '0;
      bus.in_nan     = 1'b0;
      bus.in_inf     = 1'b0;
      bus.in_zero    = 1'b0;
      bus.out_ready  = 1'b1;

      #3;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_result", bus.out_result, 32'h0);
      chk("rst_flags", bus.out_flags, 3'b000);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed("one",      48'h400000000000, 1'b0, 254, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b000);
      directed("onehalf",  48'h900000000000, 1'b0, 254, 1'b0, 1'b0, 1'b0, 32'h40100000, 3'b000);
      directed("tie_even", 48'h400000400000, 1'b0, 254, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001);
      directed("tie_odd",  48'h400000C00000, 1'b0, 254, 1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b001);
      directed("carry",    48'h7FFFFFC00000, 1'b0, 254, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001);
      directed("overflow", 48'h400000000000, 1'b1, 400, 1'b0, 1'b0, 1'b0, 32'hFF800000, 3'b101);
      directed("underflow",48'h400000000000, 1'b0, 100, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011);
      directed("nan",  {16'($urandom), 32'($urandom)}, 1'b1, $urandom_range(0, 508),
               1'b1, 1'b1, 1'b1, 32'h7FC00000, 3'b000);
      directed("inf",  {16'($urandom), 32'($urandom)}, 1'b1, $urandom_range(0, 508),
               1'b0, 1'b1, 1'b0, 32'hFF800000, 3'b000);
      directed("zero", {16'($urandom), 32'($urandom)}, 1'b1, $urandom_range(0, 508),
               1'b0, 1'b0, 1'b1, 32'h80000000, 3'b000);

      // Backpressure: five items, consumer stalled during cycles 3..6.
      begin
         int  sent = 0;
         logic saw_low = 1'b0;
         rand_inputs();
         for (int cyc = 1; cyc <= 30 && (sent < 5 || expq.size() != 0); cyc++) begin
            bus.in_valid  = (sent < 5);
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            if (!bus.in_ready) saw_low = 1'b1;
            cycle();
            if (accepted) begin
               sent++;
               rand_inputs();
            end
         end
         chk("bp_in_ready_dropped", saw_low, 1'b1);
         chk("bp_all_sent", sent, 5);
         chk("bp_drained", expq.size(), 0);
      end

      // Randomized stream with random backpressure.
      for (int k = 0; k < 400; k++) begin
         rand_inputs();
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10 && expq.size() != 0; k++) cycle();
      chk("rand_drained", expq.size(), 0);

      // Reset while two items are held under backpressure.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rand_inputs();
         bus.in_valid = 1'b1;
         cycle();
      end
      chk("pre_rst_valid", bus.out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_result", bus.out_result, 32'h0);
      chk("midrst_flags", bus.out_flags, 3'b000);
      expq.delete();
      occ     = 0;
      stalled = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      directed("post_rst", 48'h900000000000, 1'b1, 254, 1'b0, 1'b0, 1'b0, 32'hC0100000, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
